// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline: load-use, branch squash,
// data-memory freeze and MULT/DIV occupancy, plus stall/flush counters and a watchdog.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int MDU_CW  = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        id_mdu_start,
    input  logic        id_mdu_read,
    input  logic        dmem_stall,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_write,
    output logic        mdu_busy,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic        stall_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FREEZE   = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [MDU_CW-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic [31:0]       flush_cnt_q, flush_cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;

    logic load_use;
    logic mdu_hazard;
    logic mdu_accept;
    logic busy;

    assign busy       = (mdu_cnt_q != '0);
    assign load_use   = ex_mem_read && (ex_rt != 5'd0) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign mdu_hazard = busy && (id_mdu_start || id_mdu_read);

    // Priority chain: freeze, branch squash, load-use bubble, MDU bubble, run.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mdu_accept   = 1'b0;
        state_d      = ST_RUN;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b0;
        end else if (dmem_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            state_d      = ST_FREEZE;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end else if (mdu_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            state_d      = ST_MDU_WAIT;
        end else begin
            mdu_accept   = id_mdu_start && !busy;
        end
    end

    // The MDU countdown keeps running through a freeze; the unit itself is not stalled.
    always_comb begin
        mdu_cnt_d   = mdu_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wd_d        = wd_q;
        if (mdu_accept) begin
            mdu_cnt_d = MDU_CW'(MDU_LAT);
        end else if (busy) begin
            mdu_cnt_d = mdu_cnt_q - MDU_CW'(1);
        end
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (if_id_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        if (!dmem_stall) begin
            wd_d = '0;
        end else if (wd_q != WD_W'(TIMEOUT)) begin
            wd_d = wd_q + WD_W'(1);
        end
        timeout_d = timeout_q || (wd_d == WD_W'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mdu_busy      = busy;
    assign state         = state_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle control vectors go through an expected queue,
// scenario tasks add inline checks on counters, watchdog and reset.
module tb_pipe_hazard_ctrl;

    localparam int MDU_LAT = 4;
    localparam int MDU_CW  = 3;
    localparam int TIMEOUT = 8;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write}
    localparam logic [4:0] C_RUN    = 5'b11001;
    localparam logic [4:0] C_STALL  = 5'b00011;
    localparam logic [4:0] C_FLUSH  = 5'b11111;
    localparam logic [4:0] C_FREEZE = 5'b00000;
    localparam logic [4:0] C_RST    = 5'b00110;
    localparam logic [1:0] S_RUN = 2'd0, S_FRZ = 2'd1, S_MDU = 2'd2;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, ex_branch_taken;
    logic        id_mdu_start, id_mdu_read, dmem_stall;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write;
    logic        mdu_busy, stall_timeout;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;
    logic [7:0]  exp_q[$];
    logic        sb_en = 1'b0;
    logic [7:0]  sb_exp;
    logic [31:0] exp_stall = '0;
    logic [31:0] exp_flush = '0;
    logic [7:0]  obs;

    assign obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mdu_busy, state};

    pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .MDU_CW(MDU_CW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read), .dmem_stall(dmem_stall),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .mdu_busy(mdu_busy),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .stall_timeout(stall_timeout)
    );

    // ---------------- clock / reset ----------------
    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    function automatic logic [7:0] v(input logic [4:0] c, input logic b, input logic [1:0] s);
        return {c, b, s};
    endfunction

    // ---------------- scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (sb_en && (exp_q.size() > 0)) begin
            sb_exp = exp_q.pop_front();
            checks++;
            if (obs !== sb_exp) begin
                failures++;
                $display("FAIL ctl_vec t=%0t got=%b exp=%b", $time, obs, sb_exp);
            end
            checks++;
            if (stall_cnt !== exp_stall) begin
                failures++;
                $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, exp_stall);
            end
            checks++;
            if (flush_cnt !== exp_flush) begin
                failures++;
                $display("FAIL flush_cnt t=%0t got=%0d exp=%0d", $time, flush_cnt, exp_flush);
            end
            if (!sb_exp[7] && (exp_stall != '1)) exp_stall = exp_stall + 32'd1;
            if (sb_exp[5] && (exp_flush != '1)) exp_flush = exp_flush + 32'd1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mrd, input logic [4:0] ert, input logic br,
                         input logic ms, input logic mr, input logic ds, input logic [7:0] e);
        id_rs = rs; id_rt = rt; id_uses_rt = uses;
        ex_mem_read = mrd; ex_rt = ert; ex_branch_taken = br;
        id_mdu_start = ms; id_mdu_read = mr; dmem_stall = ds;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [7:0] e);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic set_idle_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = '0;
        ex_branch_taken = 1'b0; id_mdu_start = 1'b0; id_mdu_read = 1'b0; dmem_stall = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_idle_inputs();
        #2;
        checks++;
        if (obs !== v(C_RST, 1'b0, S_RUN)) begin
            failures++; $display("FAIL reset_no_clk got=%b exp=%b", obs, v(C_RST, 1'b0, S_RUN));
        end
        checks++;
        if ({stall_cnt, flush_cnt, stall_timeout} !== 65'd0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d/%0b exp=0/0/0", stall_cnt, flush_cnt, stall_timeout);
        end
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== v(C_RST, 1'b0, S_RUN) || stall_cnt !== 32'd0) begin
            failures++; $display("FAIL reset_clocked got=%b cnt=%0d exp=%b cnt=0", obs, stall_cnt, v(C_RST, 1'b0, S_RUN));
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== v(C_RUN, 1'b0, S_RUN)) begin
            failures++; $display("FAIL reset_release got=%b exp=%b", obs, v(C_RUN, 1'b0, S_RUN));
        end
        exp_stall = '0;
        exp_flush = '0;
        sb_en = 1'b1;
        idle(v(C_RUN, 1'b0, S_RUN));
        idle(v(C_RUN, 1'b0, S_RUN));
    endtask

    task automatic test_load_use();
        logic [31:0] s0;
        s0 = stall_cnt;
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, v(C_STALL, 1'b0, S_RUN));
        idle(v(C_RUN, 1'b0, S_RUN));
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, v(C_RUN, 1'b0, S_RUN));
        drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, v(C_STALL, 1'b0, S_RUN));
        drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, v(C_RUN, 1'b0, S_RUN));
        drive(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, v(C_RUN, 1'b0, S_RUN));
        checks++;
        if (stall_cnt - s0 !== 32'd2) begin
            failures++; $display("FAIL load_use_stalls got=%0d exp=2", stall_cnt - s0);
        end
    endtask

    task automatic test_branch();
        logic [31:0] f0;
        f0 = flush_cnt;
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, v(C_FLUSH, 1'b0, S_RUN));
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, v(C_FREEZE, 1'b0, S_RUN));
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, v(C_FLUSH, 1'b0, S_FRZ));
        idle(v(C_RUN, 1'b0, S_RUN));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, v(C_FLUSH, 1'b0, S_RUN));
        idle(v(C_RUN, 1'b0, S_RUN));
        checks++;
        if (flush_cnt - f0 !== 32'd3) begin
            failures++; $display("FAIL branch_flushes got=%0d exp=3", flush_cnt - f0);
        end
    endtask

    task automatic test_mdu();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, v(C_RUN, 1'b0, S_RUN));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, v(C_STALL, 1'b1, S_RUN));
        for (int i = 0; i < 3; i++)
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, v(C_STALL, 1'b1, S_MDU));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, v(C_RUN, 1'b0, S_MDU));
        idle(v(C_RUN, 1'b0, S_RUN));
        checks++;
        if (state !== S_RUN) begin
            failures++; $display("FAIL mdu_final_state got=%0d exp=%0d", state, S_RUN);
        end
    endtask

    task automatic test_back_to_back();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, v(C_RUN, 1'b0, S_RUN));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, v(C_STALL, 1'b1, S_RUN));
        for (int i = 0; i < 3; i++)
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, v(C_STALL, 1'b1, S_MDU));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, v(C_RUN, 1'b0, S_MDU));
        for (int i = 0; i < MDU_LAT; i++)
            idle(v(C_RUN, 1'b1, S_RUN));
        idle(v(C_RUN, 1'b0, S_RUN));
    endtask

    task automatic test_mdu_freeze();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, v(C_RUN, 1'b0, S_RUN));
        idle_ds(v(C_FREEZE, 1'b1, S_RUN));
        idle_ds(v(C_FREEZE, 1'b1, S_FRZ));
        idle_ds(v(C_FREEZE, 1'b1, S_FRZ));
        idle(v(C_RUN, 1'b1, S_FRZ));
        checks++;
        if (mdu_busy !== 1'b0) begin
            failures++; $display("FAIL mdu_freeze_done got=%b exp=0", mdu_busy);
        end
        idle(v(C_RUN, 1'b0, S_RUN));
    endtask

    task automatic idle_ds(input logic [7:0] e);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, e);
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < TIMEOUT - 1; i++)
            idle_ds(v(C_FREEZE, 1'b0, (i == 0) ? S_RUN : S_FRZ));
        checks++;
        if (stall_timeout !== 1'b0) begin
            failures++; $display("FAIL wd_first_burst got=%b exp=0", stall_timeout);
        end
        idle(v(C_RUN, 1'b0, S_FRZ));
        for (int i = 0; i < TIMEOUT - 1; i++)
            idle_ds(v(C_FREEZE, 1'b0, (i == 0) ? S_RUN : S_FRZ));
        checks++;
        if (stall_timeout !== 1'b0) begin
            failures++; $display("FAIL wd_before_trip got=%b exp=0", stall_timeout);
        end
        idle_ds(v(C_FREEZE, 1'b0, S_FRZ));
        checks++;
        if (stall_timeout !== 1'b1) begin
            failures++; $display("FAIL wd_trip got=%b exp=1", stall_timeout);
        end
        idle(v(C_RUN, 1'b0, S_FRZ));
        idle(v(C_RUN, 1'b0, S_RUN));
        checks++;
        if (stall_timeout !== 1'b1) begin
            failures++; $display("FAIL wd_sticky got=%b exp=1", stall_timeout);
        end
    endtask

    task automatic test_async_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, v(C_RUN, 1'b0, S_RUN));
        idle(v(C_RUN, 1'b1, S_RUN));
        idle_ds(v(C_FREEZE, 1'b1, S_RUN));
        sb_en = 1'b0;
        set_idle_inputs();
        dmem_stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== v(C_RST, 1'b0, S_RUN)) begin
            failures++; $display("FAIL async_rst_ctl got=%b exp=%b", obs, v(C_RST, 1'b0, S_RUN));
        end
        checks++;
        if ({stall_cnt, flush_cnt, stall_timeout} !== 65'd0) begin
            failures++; $display("FAIL async_rst_counters got=%0d/%0d/%0b exp=0/0/0", stall_cnt, flush_cnt, stall_timeout);
        end
        dmem_stall = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        sb_en = 1'b1;
        idle(v(C_RUN, 1'b0, S_RUN));
        drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, v(C_STALL, 1'b0, S_RUN));
        idle(v(C_RUN, 1'b0, S_RUN));
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_back_to_back();
        test_mdu_freeze();
        test_watchdog();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL sb_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
